// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FSM state type and bit-reflection helper for crc32_stream.
// Pure declarations: no latency, no backpressure.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } crc_state_e;

  function automatic logic [31:0] crc32_reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_lane.sv
// One-byte CRC-32 step, byte fed LSB first into an MSB-first register; combinational, 0 cycles.
// No handshake: en=0 passes the running value through untouched.
module crc32_lane
  import crc32_pkg::*;
(
  input  logic [31:0] i_crc_in,
  input  logic [7:0]  i_byte,
  input  logic        i_en,
  output logic [31:0] o_crc_out
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = i_crc_in;
    for (int i = 0; i < 8; i++) begin
      w_crc = {w_crc[30:0], 1'b0} ^ ({32{w_crc[31] ^ i_byte[i]}} & CRC32_POLY);
    end
  end

  assign o_crc_out = i_en ? w_crc : i_crc_in;

endmodule

// File: rtl/crc32_stream.sv
// BYTES-lane Ethernet CRC-32 with per-frame registered result (FCS, length, residue flag via CRC32_CHECK_EN).
// Result 1 cycle after last beat; s_ready = !crc_valid || crc_ready, so a held result stalls input.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*BYTES-1:0] s_data,
  input  logic [BYTES-1:0]   s_keep,
  input  logic               s_last,
  output logic               crc_valid,
  input  logic               crc_ready,
  output logic [31:0]        crc_out,
  output logic [LEN_W-1:0]   frame_len,
  output logic               crc_ok
);

  localparam int CNT_W = $clog2(BYTES + 1);

  crc_state_e       r_state, w_state_next;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_crc_out;
  logic [LEN_W-1:0] r_frame_len;

  logic [BYTES-1:0] w_keep;
  logic [31:0]      w_chain [BYTES+1];
  logic [CNT_W-1:0] w_cnt;
  logic [LEN_W:0]   w_sum;
  logic [LEN_W-1:0] w_len_next;
  logic             w_acc;
  logic             w_acc_last;

  // Keep only matters on the closing beat; mid-frame beats are always full.
  assign w_keep     = s_last ? s_keep : {BYTES{1'b1}};
  assign w_acc      = s_valid && s_ready;
  assign w_acc_last = w_acc && s_last;

  assign w_chain[0] = r_crc;
  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    crc32_lane u_lane (
      .i_crc_in  (w_chain[g]),
      .i_byte    (s_data[8*g +: 8]),
      .i_en      (w_keep[g]),
      .o_crc_out (w_chain[g+1])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < BYTES; k++) w_cnt = w_cnt + CNT_W'(w_keep[k]);
  end

  assign w_sum      = {1'b0, r_len} + (LEN_W+1)'(w_cnt);
  assign w_len_next = w_sum[LEN_W] ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    crc_valid    = 1'b0;
    s_ready      = 1'b1;
    case (r_state)
      ST_ACCUM: begin
        if (w_acc_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        crc_valid = 1'b1;
        s_ready   = crc_ready;
        if (crc_ready && !w_acc_last) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Closing beat both captures the result and rearms the running state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc       <= CRC32_INIT;
      r_len       <= '0;
      r_crc_out   <= '0;
      r_frame_len <= '0;
    end else if (w_acc) begin
      if (s_last) begin
        r_crc_out   <= ~crc32_reflect32(w_chain[BYTES]);
        r_frame_len <= w_len_next;
        r_crc       <= CRC32_INIT;
        r_len       <= '0;
      end else begin
        r_crc <= w_chain[BYTES];
        r_len <= w_len_next;
      end
    end
  end

`ifdef CRC32_CHECK_EN
  logic r_crc_ok;

  always_ff @(posedge clk) begin
    if (rst)             r_crc_ok <= 1'b0;
    else if (w_acc_last) r_crc_ok <= (w_chain[BYTES] == CRC32_RESIDUE);
  end

  assign crc_ok = r_crc_ok;
`else
  assign crc_ok = 1'b0;
`endif

  assign crc_out   = r_crc_out;
  assign frame_len = r_frame_len;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: reflected-table-free CRC model feeds a result scoreboard.
module tb_crc32_stream;

  localparam int BYTES = 4;
  localparam int LEN_W = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0]      crc;
    logic [LEN_W-1:0] len;
    logic             ok;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [8*BYTES-1:0] s_data;
  logic [BYTES-1:0]   s_keep;
  logic               s_last;
  logic               crc_valid;
  logic               crc_ready;
  logic [31:0]        crc_out;
  logic [LEN_W-1:0]   frame_len;
  logic               crc_ok;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_stall = 0;
  bit   last_acc;
  exp_t exp_q[$];

  crc32_stream #(.BYTES(BYTES), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .crc_valid (crc_valid),
    .crc_ready (crc_ready),
    .crc_out   (crc_out),
    .frame_len (frame_len),
    .crc_ok    (crc_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // LSB-first reflected algorithm; returns the reflected register before final inversion.
  function automatic logic [31:0] model_reg(input bq_t b);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (b[i]) begin
      r = r ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Sample just after a falling edge, then advance to the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    if (s_valid && !s_ready) n_stall++;
    last_acc = s_valid && s_ready;
    if (crc_valid && crc_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", crc_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_crc", crc_out, e.crc);
        chk("sb_len", 32'(frame_len), 32'(e.len));
        chk("sb_ok", crc_ok, e.ok);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [8*BYTES-1:0] d, input logic [BYTES-1:0] k, input logic l);
    bit acc;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    acc     = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      step();
      acc = last_acc;
    end
    if (!acc) chk("accept_timeout", s_ready, 1);
    else if (l) chk("latency_vld", crc_valid, 1);
  endtask

  task automatic push_exp(input bq_t b);
    exp_t        e;
    logic [31:0] r;
    int          n;
    r     = model_reg(b);
    n     = b.size();
    e.crc = ~r;
    e.len = (n > (1 << LEN_W) - 1) ? {LEN_W{1'b1}} : LEN_W'(n);
`ifdef CRC32_CHECK_EN
    e.ok  = (r == 32'hDEBB20E3);
`else
    e.ok  = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input bq_t b);
    int                 n, nb, idx;
    logic [8*BYTES-1:0] d;
    logic [BYTES-1:0]   k;
    push_exp(b);
    n  = b.size();
    nb = (n == 0) ? 1 : (n + BYTES - 1) / BYTES;
    for (int bt = 0; bt < nb; bt++) begin
      d = 32'($urandom);
      k = '0;
      for (int ln = 0; ln < BYTES; ln++) begin
        idx = bt * BYTES + ln;
        if (idx < n) begin
          d[8*ln +: 8] = b[idx];
          k[ln]        = 1'b1;
        end
      end
      if (bt != nb - 1) k = BYTES'($urandom);
      send_beat(d, k, bt == nb - 1);
    end
  endtask

  task automatic drain();
    s_valid   = 1'b0;
    crc_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_crc_valid"}, crc_valid, 0);
    chk({tag, "_crc_out"}, crc_out, 32'h0);
    chk({tag, "_frame_len"}, 32'(frame_len), 0);
    chk({tag, "_crc_ok"}, crc_ok, 0);
  endtask

  initial begin
    bq_t std, chkf, bad, f1, f2, big, abc;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_keep    = '0;
    s_last    = 1'b0;
    crc_ready = 1'b1;
    std  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    abc  = '{8'h61, 8'h62, 8'h63};
    @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Standard check value, result one cycle after the last beat.
    send_frame(std);
    chk("std_crc", crc_out, 32'hCBF43926);
    chk("std_len", 32'(frame_len), 9);
    drain();

    // Frame carrying its own FCS, then the same with one payload bit flipped.
    chkf = std;
    chkf.push_back(8'h26); chkf.push_back(8'h39); chkf.push_back(8'hF4); chkf.push_back(8'hCB);
    send_frame(chkf);
    chk("fcs_len", 32'(frame_len), 13);
    bad = chkf;
    bad[4] = bad[4] ^ 8'h10;
    send_frame(bad);
    drain();

    // Empty frame: single last beat with keep 0.
    send_frame('{});
    chk("empty_crc", crc_out, 32'h0);
    chk("empty_len", 32'(frame_len), 0);
    drain();

    // Back-to-back frames with the consumer always ready.
    n_stall = 0;
    f1 = '{};
    f2 = '{};
    for (int i = 0; i < 8; i++) f1.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) f2.push_back(8'($urandom));
    send_frame(f1);
    send_frame(f2);
    chk("b2b_no_stall", 32'(n_stall), 0);
    drain();

    // Held result blocks the next closing beat and stays stable.
    crc_ready = 1'b0;
    send_frame(std);
    push_exp(abc);
    s_valid = 1'b1;
    s_data  = {8'hA5, 8'h63, 8'h62, 8'h61};
    s_keep  = 4'b0111;
    s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_s_ready", s_ready, 0);
      chk("hold_valid", crc_valid, 1);
      chk("hold_crc_stable", crc_out, 32'hCBF43926);
    end
    crc_ready = 1'b1;
    send_beat({8'hA5, 8'h63, 8'h62, 8'h61}, 4'b0111, 1'b1);
    drain();

    // Length counter saturates at 2^LEN_W-1.
    big = '{};
    for (int i = 0; i < 320; i++) big.push_back(8'($urandom));
    send_frame(big);
    chk("sat_len", 32'(frame_len), 255);
    drain();

    // Reset mid-frame, then a clean frame.
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    s_valid = 1'b0;
    rst     = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    step();
    send_frame(std);
    chk("post_rst_crc", crc_out, 32'hCBF43926);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
